pm_alu_sched: RTL
=================

# pm_alu_sched

Issue scheduler for the shared plus/minus ALU in the Tomasulo back end. It arbitrates among `NRS` add/sub reservation stations and grants one ready station at a time. It sequences the ALU through its Add or Inverse→MAdd state walk and presents the result on the common data bus (CDB) until the CDB accepts it. It replaces the ALU's free-running state logic: the ALU only consumes `alu_state`, `alu_en`, `alu_op` and the operand buses from this block.

## Interface

Parameters:
- `NRS`, 3, number of reservation stations (requesters), 2..8
- `TAGW`, 4, CDB tag width
- `TAG_BASE`, 1, tag of station 0; station i tags as `TAG_BASE+i`

Ports:
- `clk`  in  1  clock
- `nRST`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NRS  station i has both operands and requests issue
- `req_op`  in  NRS  per-station op: 0 = add, 1 = sub
- `req_a`  in  32*NRS  operand A, station i at bits [32i+31:32i]
- `req_b`  in  32*NRS  operand B, same packing
- `grant`  out  NRS  one-hot, combinational, high in the acceptance cycle
- `alu_en`  out  1  ALU operand-capture enable
- `alu_op`  out  1  op of the granted request
- `alu_a`, `alu_b`  out  32  granted operands
- `alu_state`  out  2  ALU state: 0 Idle, 1 Add, 2 Inverse, 3 MAdd
- `alu_result`  in  32  ALU combinational result
- `cdb_valid`  out  1  result offered on CDB
- `cdb_tag`  out  TAGW  tag of the producing station
- `cdb_data`  out  32  result
- `cdb_ack`  in  1  CDB accepts the result this cycle
- `busy`  out  1  state ≠ Idle

## Operation

- The FSM register drives `alu_state` directly. States: IDLE(0), ADD(1), INV(2), MADD(3).
- **Accept cycle.** An accept cycle is:
  - state IDLE with any `req_valid`, or
  - state ADD/MADD with `cdb_ack` and any `req_valid`.
- **In an accept cycle:**
  - `grant[w]=1` for the winner `w`.
  - `alu_en=1`; `alu_op`, `alu_a`, `alu_b` are taken from station `w`.
  - The tag `TAG_BASE+w` and the op are latched internally.
  - Next state is ADD if the op is add, INV if the op is sub.
- **Outside accept cycles:** `grant=0`, `alu_en=0`, and `alu_op`/`alu_a`/`alu_b` are driven to 0.
- **INV:** unconditionally goes to MADD on the next cycle. `cdb_valid=0`. The ALU inverts B.
- **ADD/MADD:**
  - `cdb_valid=1`, `cdb_tag` = latched tag, `cdb_data=alu_result`.
  - Hold the state until `cdb_ack`.
  - On `cdb_ack` with no request pending, go to IDLE.
- **ALU contract (bench model):** result is `a+b` in ADD and `a-b` in MADD, two's complement modulo 2^32.
- **Requester rules:**
  - A station holds `req_valid`, op and operands stable until granted.
  - It drops `req_valid` in the cycle after `grant`.
  - A station may not withdraw `req_valid` before it is granted.
- **Arbitration:** round-robin, with a pointer `last` that updates to `w` on each accept. Search order is `last+1`, `last+2`, … mod NRS.
- `cdb_ack` while `cdb_valid=0` is ignored.
- Outside ADD/MADD: `cdb_tag=0`, `cdb_data=0`.

## Timing

- **Reset values** (asynchronous, immediate on `nRST` low):
  - state IDLE, `last=NRS-1` (station 0 wins first).
  - All outputs 0: `grant`, `alu_en`, `alu_op`, `alu_a`, `alu_b`, `alu_state`, `cdb_valid`, `cdb_tag`, `cdb_data`, `busy`.
- **Reset mid-operation:** the in-flight op is discarded and no CDB broadcast occurs. The first accept after `nRST` rises occurs no earlier than the first rising edge.
- **Latency from grant cycle T:**
  - add: `cdb_valid` at T+1.
  - sub: INV at T+1, `cdb_valid` at T+2.
- **Throughput with `cdb_ack` tied high:** one add per cycle, one sub per 2 cycles. Back-to-back issue uses the acknowledging cycle as the next accept cycle, so there is no idle bubble.
- **CDB stall:** `cdb_valid`, `cdb_tag` and `cdb_data` stay stable while `cdb_ack=0`, provided the ALU holds its result. No grant occurs during a stall.

## Configuration

- `PM_SCHED_RR_EN` defined: round-robin arbitration as specified.
- `PM_SCHED_RR_EN` undefined: fixed priority, lowest index wins; `last` is not implemented. All other behaviour is identical.

## Test plan

- **Reset:** drive nRST=0 mid-sub (state INV). All outputs go 0 immediately. After release with no requests, `busy=0` and `cdb_valid=0`.
- **Single add:** station 1 requests 5+7, `cdb_ack=1`. `grant=3'b010` at T. At T+1: `alu_state=1`, `cdb_valid=1`, `cdb_tag=2`, `cdb_data=12`. IDLE at T+2.
- **Single sub with stall:** station 0 requests 3−5, `cdb_ack` held 0 for 3 cycles. INV at T+1. MADD with `cdb_data=32'hFFFFFFFE` and `cdb_tag=1` held from T+2 through the ack cycle. No grant during the stall.
- **Round-robin:** all 3 stations add continuously, `cdb_ack=1`. Grants go 0,1,2,0 on consecutive cycles. Without `PM_SCHED_RR_EN`, station 0 is granted each cycle it requests.
- **Back-to-back mixed:** station 2 sub, then station 0 add accepted in the sub's ack cycle. CDB tags 3 then 1 on consecutive valid cycles, with no IDLE between them.
- **Spurious ack:** `cdb_ack=1` in IDLE and INV causes no state change and no `cdb_valid`.

Source files
------------

// File: rtl/pm_alu_sched_if.sv
// Scheduler <-> reservation stations / ALU / CDB bundle. master = environment side, slave = scheduler.
interface pm_alu_sched_if #(
  parameter int NRS  = 3,
  parameter int TAGW = 4
);
  logic [NRS-1:0]      req_valid;
  logic [NRS-1:0]      req_op;
  logic [32*NRS-1:0]   req_a;
  logic [32*NRS-1:0]   req_b;
  logic [NRS-1:0]      grant;
  logic                alu_en;
  logic                alu_op;
  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic [1:0]          alu_state;
  logic [31:0]         alu_result;
  logic                cdb_valid;
  logic [TAGW-1:0]     cdb_tag;
  logic [31:0]         cdb_data;
  logic                cdb_ack;
  logic                busy;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, cdb_ack,
    input  grant, alu_en, alu_op, alu_a, alu_b, alu_state, cdb_valid, cdb_tag, cdb_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, cdb_ack,
    output grant, alu_en, alu_op, alu_a, alu_b, alu_state, cdb_valid, cdb_tag, cdb_data, busy
  );
endinterface

// File: rtl/pm_alu_sched.sv
// Plus/minus ALU issue scheduler: grant at T, add result on CDB at T+1, sub at T+2; result held until cdb_ack, no grant while stalled.
// PM_SCHED_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest station wins).
module pm_alu_sched #(
  parameter int NRS      = 3,
  parameter int TAGW     = 4,
  parameter int TAG_BASE = 1
) (
  input  logic           clk,
  input  logic           nRST,
  pm_alu_sched_if.slave  bus
);
  localparam int IDXW = $clog2(NRS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INV  = 2'd2,
    MADD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            run_q;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [IDXW-1:0] win;
  logic            out_phase;
  logic            accept;

`ifdef PM_SCHED_RR_EN
  logic [IDXW-1:0] last_q;
  logic [IDXW-1:0] idx;
  logic            hit;

  always_comb begin
    win = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 1; k <= NRS; k++) begin
      idx = IDXW'((int'(last_q) + k) % NRS);
      if (!hit && bus.req_valid[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)       last_q <= IDXW'(NRS - 1);
    else if (accept) last_q <= win;
  end
`else
  always_comb begin
    win = '0;
    for (int i = NRS - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) win = IDXW'(i);
    end
  end
`endif

  assign out_phase = (state_q == ADD) || (state_q == MADD);
  // run_q keeps grants off until the first edge after reset release
  assign accept = run_q && (|bus.req_valid) &&
                  ((state_q == IDLE) || (out_phase && bus.cdb_ack));

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    bus.grant     = '0;
    bus.alu_en    = 1'b0;
    bus.alu_op    = 1'b0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    case (state_q)
      INV:      state_d = MADD;
      ADD,
      MADD:     if (bus.cdb_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (accept) begin
      bus.grant[win] = 1'b1;
      bus.alu_en     = 1'b1;
      bus.alu_op     = bus.req_op[win];
      bus.alu_a      = bus.req_a[32*int'(win) +: 32];
      bus.alu_b      = bus.req_b[32*int'(win) +: 32];
      tag_d          = TAGW'(TAG_BASE) + TAGW'(win);
      state_d        = bus.req_op[win] ? INV : ADD;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      tag_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      run_q   <= 1'b1;
    end
  end

  assign bus.alu_state = state_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cdb_valid = out_phase;
  assign bus.cdb_tag   = out_phase ? tag_q : '0;
  assign bus.cdb_data  = out_phase ? bus.alu_result : '0;
endmodule
